// File: rtl/l1ca_code_ctrl_pkg.sv
// rtl/l1ca_code_ctrl_pkg.sv - shared types and constants for the L1 C/A code sequencer
package l1ca_code_ctrl_pkg;

  localparam int L1CA_CODE_LEN     = 1023;
  localparam int L1CA_CHIP_RATE_HZ = 1_023_000;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_START = 2'd1,
    OP_SLEW  = 2'd2,
    OP_STOP  = 2'd3
  } code_ctrl_op_t;

  typedef logic [1:0] code_ctrl_state_t;

  localparam code_ctrl_state_t ST_IDLE = 2'd0;
  localparam code_ctrl_state_t ST_LOAD = 2'd1;
  localparam code_ctrl_state_t ST_RUN  = 2'd2;
  localparam code_ctrl_state_t ST_SLEW = 2'd3;

  // Commands are only taken in the two steady states.
  function automatic logic accepts_cmd(input code_ctrl_state_t s);
    return (s == ST_IDLE) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/l1ca_code_ctrl_if.sv
// rtl/l1ca_code_ctrl_if.sv - command channel into the code sequencer
interface l1ca_code_ctrl_if
  import l1ca_code_ctrl_pkg::*;
#(
  parameter int NCO_W  = 32,
  parameter int SLEW_W = 10
);

  logic              cmd_valid;
  logic              cmd_ready;
  code_ctrl_op_t     cmd_op;
  logic [4:0]        cmd_sv;
  logic [NCO_W-1:0]  cmd_fcw;
  logic [SLEW_W-1:0] cmd_slew;

  modport master (
    output cmd_valid, cmd_op, cmd_sv, cmd_fcw, cmd_slew,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_sv, cmd_fcw, cmd_slew,
    output cmd_ready
  );

endinterface

// File: rtl/l1ca_code_ctrl_code_nco.sv
// rtl/l1ca_code_ctrl_code_nco.sv - code NCO accumulator producing one carry per chip
module code_nco #(
  parameter int NCO_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [NCO_W-1:0] fcw,
  output logic [NCO_W-1:0] acc,
  output logic             carry
);

  logic [NCO_W:0] sum;

  always_comb begin
    sum   = {1'b0, acc} + {1'b0, fcw};
    carry = en & sum[NCO_W];
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum[NCO_W-1:0];
    end
  end

endmodule

// File: rtl/l1ca_code_ctrl.sv
// rtl/l1ca_code_ctrl.sv - START/SLEW/STOP sequencer pacing one l1ca_code generator
module l1ca_code_ctrl
  import l1ca_code_ctrl_pkg::*;
#(
  parameter int NCO_W       = 32,
  parameter int EPOCH_CNT_W = 16,
  parameter int SLEW_W      = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_en,
  l1ca_code_ctrl_if.slave        cmd,
  output logic                   gen_en,
  output logic                   gen_clear,
  output logic [4:0]             gen_sv,
  input  logic                   gen_epoch,
  output logic                   running,
  output logic                   epoch_pulse,
  output logic [EPOCH_CNT_W-1:0] epoch_cnt,
  output logic [NCO_W-1:0]       code_phase
);

  code_ctrl_state_t  state;
  code_ctrl_state_t  state_nx;
  logic [NCO_W-1:0]  fcw;
  logic [SLEW_W-1:0] slew_cnt;
  logic              gen_epoch_q;
  logic              accept;
  logic              nco_en;
  logic              nco_clear;
  logic              nco_carry;
  logic              epoch_rise;

  assign accept     = cmd.cmd_valid & cmd.cmd_ready;
  assign nco_en     = (state == ST_RUN) & sample_en;
  assign nco_clear  = (state == ST_LOAD);
  assign epoch_rise = gen_epoch & ~gen_epoch_q & ((state == ST_RUN) || (state == ST_SLEW));

  code_nco #(.NCO_W(NCO_W)) u_nco (
    .clk   (clk),
    .rst   (rst),
    .clear (nco_clear),
    .en    (nco_en),
    .fcw   (fcw),
    .acc   (code_phase),
    .carry (nco_carry)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept && cmd.cmd_op == OP_START) state_nx = ST_LOAD;
      ST_LOAD: state_nx = ST_RUN;
      ST_RUN: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_START: state_nx = ST_LOAD;
            OP_STOP:  state_nx = ST_IDLE;
            OP_SLEW:  if (cmd.cmd_slew != '0) state_nx = ST_SLEW;
            default:  state_nx = ST_RUN;
          endcase
        end
      end
      ST_SLEW: if (slew_cnt == SLEW_W'(1)) state_nx = ST_RUN;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cmd.cmd_ready <= 1'b0;
      running       <= 1'b0;
      gen_clear     <= 1'b1;
      gen_en        <= 1'b0;
      gen_sv        <= '0;
      fcw           <= '0;
      slew_cnt      <= '0;
      gen_epoch_q   <= 1'b0;
      epoch_pulse   <= 1'b0;
      epoch_cnt     <= '0;
    end else begin
      state         <= state_nx;
      cmd.cmd_ready <= accepts_cmd(state_nx);
      running       <= (state_nx == ST_RUN) || (state_nx == ST_SLEW);
      gen_clear     <= (state_nx == ST_IDLE) || (state_nx == ST_LOAD);

      if (accept && cmd.cmd_op == OP_START) begin
        gen_sv <= cmd.cmd_sv;
        fcw    <= cmd.cmd_fcw;
      end

      if (state == ST_RUN && state_nx == ST_SLEW) begin
        slew_cnt <= cmd.cmd_slew;
      end else if (state == ST_SLEW) begin
        slew_cnt <= slew_cnt - 1'b1;
      end

      // The carry from the cycle that enters SLEW still goes out as a chip.
      if (state == ST_SLEW) begin
        gen_en <= 1'b1;
      end else if (state == ST_RUN && (state_nx == ST_RUN || state_nx == ST_SLEW)) begin
        gen_en <= nco_carry;
      end else begin
        gen_en <= 1'b0;
      end

      if (state == ST_LOAD) begin
        gen_epoch_q <= 1'b0;
        epoch_pulse <= 1'b0;
        epoch_cnt   <= '0;
      end else begin
        gen_epoch_q <= gen_epoch;
        epoch_pulse <= epoch_rise;
        if (epoch_rise) epoch_cnt <= epoch_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l1ca_code_ctrl.sv
// tb/tb_l1ca_code_ctrl.sv - directed bench for l1ca_code_ctrl with a chip-counter generator model
module tb_l1ca_code_ctrl;
  import l1ca_code_ctrl_pkg::*;

  localparam int NCO_W  = 32;
  localparam int SLEW_W = 10;
  localparam int EW     = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_en = 1'b0;
  always #5 clk = ~clk;

  l1ca_code_ctrl_if #(.NCO_W(NCO_W), .SLEW_W(SLEW_W)) cmd ();
  l1ca_code_ctrl_if #(.NCO_W(NCO_W), .SLEW_W(SLEW_W)) cmd2 ();

  logic             gen_en, gen_clear, gen_epoch, running, epoch_pulse;
  logic [4:0]       gen_sv;
  logic [EW-1:0]    epoch_cnt;
  logic [NCO_W-1:0] code_phase;

  logic             gen_en2, gen_clear2, gen_epoch2, running2, epoch_pulse2;
  logic [4:0]       gen_sv2;
  logic [1:0]       epoch_cnt2;
  logic [NCO_W-1:0] code_phase2;

  l1ca_code_ctrl #(.NCO_W(NCO_W), .EPOCH_CNT_W(EW), .SLEW_W(SLEW_W)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .cmd(cmd.slave),
    .gen_en(gen_en), .gen_clear(gen_clear), .gen_sv(gen_sv), .gen_epoch(gen_epoch),
    .running(running), .epoch_pulse(epoch_pulse), .epoch_cnt(epoch_cnt), .code_phase(code_phase)
  );

  l1ca_code_ctrl #(.NCO_W(NCO_W), .EPOCH_CNT_W(2), .SLEW_W(SLEW_W)) dut2 (
    .clk(clk), .rst(rst), .sample_en(sample_en), .cmd(cmd2.slave),
    .gen_en(gen_en2), .gen_clear(gen_clear2), .gen_sv(gen_sv2), .gen_epoch(gen_epoch2),
    .running(running2), .epoch_pulse(epoch_pulse2), .epoch_cnt(epoch_cnt2), .code_phase(code_phase2)
  );

  // Generator stand-in: chip index 0..1022, epoch level during chip 0 after a full period.
  logic [9:0] chip, chip2;
  logic       wrapped, wrapped2;

  always @(posedge clk) begin
    if (gen_clear) begin
      chip <= 10'd0; wrapped <= 1'b0;
    end else if (gen_en) begin
      if (chip == 10'd1022) begin chip <= 10'd0; wrapped <= 1'b1; end
      else chip <= chip + 10'd1;
    end
    if (gen_clear2) begin
      chip2 <= 10'd0; wrapped2 <= 1'b0;
    end else if (gen_en2) begin
      if (chip2 == 10'd1022) begin chip2 <= 10'd0; wrapped2 <= 1'b1; end
      else chip2 <= chip2 + 10'd1;
    end
  end
  assign gen_epoch  = wrapped  && (chip  == 10'd0);
  assign gen_epoch2 = wrapped2 && (chip2 == 10'd0);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input code_ctrl_op_t op, input logic [4:0] sv,
                      input logic [NCO_W-1:0] fcw, input logic [SLEW_W-1:0] slew);
    cmd.cmd_op = op; cmd.cmd_sv = sv; cmd.cmd_fcw = fcw; cmd.cmd_slew = slew;
    cmd.cmd_valid = 1'b1;
    step(1);
    cmd.cmd_valid = 1'b0;
  endtask

  task automatic send2(input code_ctrl_op_t op, input logic [4:0] sv, input logic [NCO_W-1:0] fcw);
    cmd2.cmd_op = op; cmd2.cmd_sv = sv; cmd2.cmd_fcw = fcw; cmd2.cmd_slew = '0;
    cmd2.cmd_valid = 1'b1;
    step(1);
    cmd2.cmd_valid = 1'b0;
  endtask

  typedef struct {
    code_ctrl_op_t     op;
    logic [4:0]        sv;
    logic [NCO_W-1:0]  fcw;
    logic [SLEW_W-1:0] slew;
    int                wait_n;
    logic              e_run;
    logic              e_rdy;
    logic              e_clr;
    logic [4:0]        e_sv;
  } vec_t;

  vec_t vt[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, m, idx, found, c0, nclr;

    vt[0] = '{OP_NOP,   5'd0,  32'd0, 10'd0, 0, 1'b0, 1'b1, 1'b1, 5'd0};
    vt[1] = '{OP_SLEW,  5'd0,  32'd0, 10'd5, 0, 1'b0, 1'b1, 1'b1, 5'd0};
    vt[2] = '{OP_STOP,  5'd0,  32'd0, 10'd0, 0, 1'b0, 1'b1, 1'b1, 5'd0};
    vt[3] = '{OP_START, 5'd7,  32'd0, 10'd0, 0, 1'b0, 1'b0, 1'b1, 5'd7};
    vt[4] = '{OP_NOP,   5'd9,  32'd0, 10'd0, 0, 1'b1, 1'b1, 1'b0, 5'd7};
    vt[5] = '{OP_SLEW,  5'd0,  32'd0, 10'd0, 0, 1'b1, 1'b1, 1'b0, 5'd7};
    vt[6] = '{OP_SLEW,  5'd0,  32'd0, 10'd3, 2, 1'b1, 1'b0, 1'b0, 5'd7};
    vt[7] = '{OP_STOP,  5'd0,  32'd0, 10'd0, 0, 1'b0, 1'b1, 1'b1, 5'd7};
    vt[8] = '{OP_START, 5'd31, 32'd0, 10'd0, 0, 1'b0, 1'b0, 1'b1, 5'd31};

    cmd.cmd_valid = 1'b0; cmd.cmd_op = OP_NOP; cmd.cmd_sv = '0; cmd.cmd_fcw = '0; cmd.cmd_slew = '0;
    cmd2.cmd_valid = 1'b0; cmd2.cmd_op = OP_NOP; cmd2.cmd_sv = '0; cmd2.cmd_fcw = '0; cmd2.cmd_slew = '0;

    for (int i = 0; i < 3; i++) begin
      step(1);
      chk($sformatf("rst%0d_ready", i), cmd.cmd_ready, 0);
      chk($sformatf("rst%0d_clear", i), gen_clear, 1);
      chk($sformatf("rst%0d_en", i), gen_en, 0);
      chk($sformatf("rst%0d_running", i), running, 0);
      chk($sformatf("rst%0d_epoch_cnt", i), epoch_cnt, 0);
    end
    rst = 1'b0;
    step(1);
    chk("post_rst_ready", cmd.cmd_ready, 1);
    chk("post_rst_clear", gen_clear, 1);
    chk("post_rst_phase", code_phase, 0);

    for (int i = 0; i < 9; i++) begin
      send(vt[i].op, vt[i].sv, vt[i].fcw, vt[i].slew);
      chk($sformatf("vec%0d_running", i), running, vt[i].e_run);
      chk($sformatf("vec%0d_ready", i), cmd.cmd_ready, vt[i].e_rdy);
      chk($sformatf("vec%0d_clear", i), gen_clear, vt[i].e_clr);
      chk($sformatf("vec%0d_sv", i), gen_sv, vt[i].e_sv);
      step(1 + vt[i].wait_n);
    end

    // Half-rate NCO: one chip per two samples, first epoch after 1023 chips.
    sample_en = 1'b1;
    send(OP_START, 5'd0, 32'h8000_0000, 10'd0);
    n = 0; found = 0; idx = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      step(1);
      if (epoch_pulse) begin found = 1; idx = i; end
      else if (gen_en) n++;
    end
    chk("epoch_found", found, 1);
    chk("epoch_chips", n, 1023);
    chk("epoch_cycle", idx, 2048);
    chk("epoch_cnt_1", epoch_cnt, 1);
    step(1);
    chk("epoch_pulse_width", epoch_pulse, 0);

    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      if (chip == 10'd100) found = 1;
      else step(1);
    end
    chk("reach_chip100", found, 1);
    sample_en = 1'b0;
    step(3);
    c0 = int'(chip);
    send(OP_SLEW, 5'd0, 32'd0, 10'd500);
    n = 0; m = 0;
    for (int i = 0; i < 510; i++) begin
      if (!cmd.cmd_ready) n++;
      if (gen_en) m++;
      step(1);
    end
    chk("slew_busy_cycles", n, 500);
    chk("slew_pulses", m, 500);
    chk("slew_chip", chip, c0 + 500);
    chk("slew_back_running", running, 1);
    chk("slew_back_ready", cmd.cmd_ready, 1);

    sample_en = 1'b1;
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      if (chip == 10'd700) found = 1;
      else step(1);
    end
    chk("reach_chip700", found, 1);
    send(OP_START, 5'd5, 32'h8000_0000, 10'd0);
    chk("restart_load_clear", gen_clear, 1);
    chk("restart_sv", gen_sv, 5);
    step(1);
    chk("restart_run_clear", gen_clear, 0);
    chk("restart_chip", chip, 0);
    chk("restart_epoch_cnt", epoch_cnt, 0);
    nclr = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (gen_clear) nclr++;
    end
    chk("restart_no_more_clear", nclr, 0);

    send(OP_STOP, 5'd0, 32'd0, 10'd0);
    chk("stop_clear", gen_clear, 1);
    chk("stop_running", running, 0);
    chk("stop_ready", cmd.cmd_ready, 1);
    send(OP_SLEW, 5'd0, 32'd0, 10'd10);
    chk("idle_slew_ready", cmd.cmd_ready, 1);
    m = 0;
    for (int i = 0; i < 12; i++) begin
      if (gen_en || running) m++;
      step(1);
    end
    chk("idle_slew_ignored", m, 0);
    chk("idle_chip", chip, 0);

    send(OP_START, 5'd3, 32'h8000_0000, 10'd0);
    step(2);
    sample_en = 1'b0;
    step(2);
    send(OP_SLEW, 5'd0, 32'd0, 10'd800);
    n = 0;
    for (int i = 0; i < 300 && n < 200; i++) begin
      if (gen_en) n++;
      if (n < 200) step(1);
    end
    chk("midslew_pulses", n, 200);
    rst = 1'b1;
    step(1);
    chk("abort_en", gen_en, 0);
    chk("abort_running", running, 0);
    chk("abort_clear", gen_clear, 1);
    chk("abort_ready", cmd.cmd_ready, 0);
    chk("abort_sv", gen_sv, 0);
    chk("abort_phase", code_phase, 0);
    rst = 1'b0;
    m = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (gen_en) m++;
    end
    chk("abort_no_en", m, 0);
    chk("abort_ready_back", cmd.cmd_ready, 1);

    // Two-bit epoch counter wraps 3 -> 0, so the fifth epoch reads 1.
    sample_en = 1'b1;
    send2(OP_START, 5'd1, 32'hFFFF_FFFF);
    n = 0; c0 = -1;
    for (int i = 0; i < 8000 && n < 5; i++) begin
      step(1);
      if (epoch_pulse2) begin
        n++;
        if (n == 4) c0 = int'(epoch_cnt2);
      end
    end
    chk("w2_epochs_seen", n, 5);
    chk("w2_cnt_at_4", c0, 0);
    chk("w2_cnt_at_5", epoch_cnt2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
